// File: rtl/freq_divider.sv
// Programmable square-wave divider: PSI is high for 2^WIDTH-D cycles, then low for the
// same count. A new divisor is adopted only at the LOW->HIGH boundary of a period.
module freq_divider #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_DIV = 8'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] divIn,
    output logic             PSI,
    output logic             co,
    output logic             periodDone,
    output logic             busy,
    output logic [WIDTH-1:0] curDiv
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic             at_max;

    assign at_max = (cnt_q == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_div_q <= RESET_DIV;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    cur_div_d = divIn;
                    cnt_d     = divIn;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (at_max) begin
                    // LOW reuses the divisor latched for this period
                    cnt_d   = cur_div_q;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (!at_max) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (en) begin
                    cur_div_d = divIn;
                    cnt_d     = divIn;
                    state_d   = HIGH;
                end else begin
                    // counter parks at MAX while idle
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign co         = busy & at_max;
    assign periodDone = co & (state_q == LOW);
    assign PSI        = (state_q == HIGH);
    assign curDiv     = cur_div_q;

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: a vector table for reset, basic divide, divisor
// update and graceful stop, plus hand-written sequences for extreme divisors and reset.
module tb_freq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] divIn;
    logic       PSI;
    logic       co;
    logic       periodDone;
    logic       busy;
    logic [7:0] curDiv;

    int n_checks = 0;
    int n_pass   = 0;

    freq_divider #(.WIDTH(8), .RESET_DIV(8'h7F)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .divIn      (divIn),
        .PSI        (PSI),
        .co         (co),
        .periodDone (periodDone),
        .busy       (busy),
        .curDiv     (curDiv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] div;
        logic       psi;
        logic       co;
        logic       pd;
        logic       busy;
        logic [7:0] cd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [7:0] d,
                       input logic p, input logic c, input logic pd,
                       input logic b, input logic [7:0] cd);
        vec_t v;
        v.rst = r; v.en = e; v.div = d;
        v.psi = p; v.co = c; v.pd = pd; v.busy = b; v.cd = cd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int high_len;
        int low_len;
        int bad;
        int pd_cnt;
        int pd_at;
        logic [4:0] got;
        logic [4:0] exp;

        rst = 1'b1; en = 1'b0; divIn = 8'h00;

        //   rst en  div    psi co pd busy curDiv
        add(1, 1, 8'hFC, 0, 0, 0, 0, 8'h7F);
        add(1, 1, 8'hFC, 0, 0, 0, 0, 8'h7F);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 1, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 0, 1, 1, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 1, 1, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 0, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFE, 0, 1, 1, 1, 8'hFC);
        add(0, 1, 8'hFE, 1, 0, 0, 1, 8'hFE);
        add(0, 1, 8'hFE, 1, 1, 0, 1, 8'hFE);
        add(0, 1, 8'hFC, 0, 0, 0, 1, 8'hFE);
        add(0, 1, 8'hFC, 0, 1, 1, 1, 8'hFE);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 1, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 1, 0, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 1, 1, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 1, 8'hFC);
        add(0, 0, 8'hFC, 0, 1, 1, 1, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 0, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 0, 8'hFC);
        add(0, 0, 8'hFC, 0, 0, 0, 0, 8'hFC);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; divIn = vecs[i].div;
            step();
            got = {PSI, co, periodDone, busy, 1'b0};
            exp = {vecs[i].psi, vecs[i].co, vecs[i].pd, vecs[i].busy, 1'b0};
            chk($sformatf("vec%0d_psi_co_pd_busy", i), 32'(got), 32'(exp));
            chk($sformatf("vec%0d_curDiv", i), 32'(curDiv), 32'(vecs[i].cd));
        end

        // D=FF: one cycle per phase, co continuously high
        en = 1'b1; divIn = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("dff_cyc%0d", i), 32'({PSI, co, periodDone}),
                32'({(i % 2 == 0), 1'b1, (i % 2 == 1)}));
        end

        // D=00: 256 high, 256 low, one periodDone per 512 cycles
        rst = 1'b1; en = 1'b0; step();
        rst = 1'b0; en = 1'b1; divIn = 8'h00;
        bad = 0; pd_cnt = 0; pd_at = -1;
        for (int i = 0; i < 512; i++) begin
            step();
            if (PSI !== (i < 256)) bad++;
            if (co !== (i == 255 || i == 511)) bad++;
            if (periodDone === 1'b1) begin
                pd_cnt++;
                pd_at = i;
            end
        end
        chk("d00_wave_mismatches", 32'(bad), 32'd0);
        chk("d00_pd_count", 32'(pd_cnt), 32'd1);
        chk("d00_pd_cycle", 32'(pd_at), 32'd511);
        step();
        chk("d00_next_period_psi", 32'(PSI), 32'd1);

        // D=80: reset during cycle 10 of HIGH, then restart with en held
        rst = 1'b1; en = 1'b0; step();
        rst = 1'b0; en = 1'b1; divIn = 8'h80;
        for (int i = 0; i < 9; i++) step();
        chk("d80_high_before_rst", 32'(PSI), 32'd1);
        rst = 1'b1; step();
        chk("d80_rst_psi_busy", 32'({PSI, busy, co}), 32'd0);
        chk("d80_rst_curDiv", 32'(curDiv), 32'h7F);
        rst = 1'b0; step();
        chk("d80_restart_psi", 32'(PSI), 32'd1);
        chk("d80_restart_curDiv", 32'(curDiv), 32'h80);
        high_len = 0;
        while (PSI === 1'b1 && high_len < 300) begin
            high_len++;
            step();
        end
        chk("d80_high_len", 32'(high_len), 32'd128);
        low_len = 0;
        while (PSI === 1'b0 && low_len < 300) begin
            low_len++;
            step();
        end
        chk("d80_low_len", 32'(low_len), 32'd128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/freq_divider.md
# freq_divider

Programmable frequency divider that generates the square-wave signal PSI whose period is set by an 8-bit divisor. It sits directly upstream of the frequency-regulator measurement stage. That stage measures PSI's high duration and returns an adjusted divisor, which closes the loop into `divIn`. A new divisor takes effect only at full-period boundaries, so the measurement stage never sees a truncated or mixed-length high phase.

## Interface
- `WIDTH`, 8, counter and divisor width
- `RESET_DIV`, 8'h7F, value of `curDiv` after reset (matches the regulator's reset divisor)

Ports:
- `clk`  in  1  system clock, all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- `en`  in  1  run request; sampled every edge
- `divIn`  in  WIDTH  requested divisor, from the regulator's adjusted divisor
- `PSI`  out  1  generated square wave; high in HIGH state only
- `co`  out  1  counter carry-out: counter at all-ones while running
- `periodDone`  out  1  one-cycle strobe on the last cycle of each full period
- `busy`  out  1  state != IDLE
- `curDiv`  out  WIDTH  divisor in use for the current period

## Operation
- States: IDLE, HIGH, LOW. Internal up counter `cnt` is WIDTH bits. MAX = 2^WIDTH-1.
- Reset values: state=IDLE, `cnt`=0, `curDiv`=RESET_DIV, PSI=0, co=0, periodDone=0, busy=0. `rst` has priority over everything.
- IDLE: `cnt` holds. If `en`=1: `curDiv`<=`divIn`, `cnt`<=`divIn`, go to HIGH.
- HIGH, `cnt`!=MAX: `cnt`<=`cnt`+1.
- HIGH, `cnt`==MAX: `cnt`<=`curDiv`, go to LOW. `curDiv` is unchanged.
- LOW, `cnt`!=MAX: `cnt`<=`cnt`+1.
- LOW, `cnt`==MAX, with `en`=1: `curDiv`<=`divIn`, `cnt`<=`divIn`, go to HIGH.
- LOW, `cnt`==MAX, with `en`=0: go to IDLE and leave `cnt` at MAX.
- Outputs:
  - `co` = (state!=IDLE) & (`cnt`==MAX), combinational.
  - `periodDone` = `co` & (state==LOW).
  - PSI = (state==HIGH).
  - busy = (state!=IDLE).
- Phase length is 2^WIDTH - D cycles, where D is the divisor. D=0 gives 256 cycles per phase; D=MAX gives 1 cycle per phase. There is no illegal divisor value.
- `divIn` changes mid-period are ignored until the next LOW→HIGH boundary. HIGH and LOW of one period always use the same D.
- `en` deasserted mid-period does not cut the period short: the current HIGH and LOW complete in full, then the block enters IDLE. Re-asserting `en` before the end of LOW continues seamlessly.
- Counter arithmetic is modulo 2^WIDTH; the counter never wraps in practice because it is reloaded at MAX.

## Timing
- Start: `en`=1 sampled at edge k in IDLE. PSI=1 and busy=1 from after edge k, with `cnt`=D.
- HIGH then lasts exactly 2^WIDTH-D cycles. PSI falls at the edge following the cycle where `co`=1.
- Back-to-back periods have no gap. Full period = 2·(2^WIDTH-D) cycles.
- `co` is high in the last cycle of each phase. `periodDone` is high in the last LOW cycle only.
- The new `curDiv` is visible in the first HIGH cycle of the new period.
- `rst` asserted at edge r in any state: all outputs are at reset values after edge r. `en` is ignored in the same edge.
- After `rst` deasserts, `en`=1 starts a period on the next edge.

## Test plan
- Reset: hold `rst` 2 cycles with `en`=1 → PSI=0, co=0, periodDone=0, busy=0, `curDiv`=8'h7F. On the first edge after release, PSI=1 and `curDiv`=`divIn`.
- Basic divide, `divIn`=8'hFC, `en`=1:
  - PSI runs 4 high / 4 low repeatedly.
  - `co` is high on cycles 4 and 8 of each period.
  - `periodDone` is high on cycle 8 only.
- Divisor update, `divIn`=8'hFC then 8'hFE during cycle 2 of HIGH:
  - the current period stays 4/4;
  - the next period is 2/2;
  - `curDiv` changes 0xFC→0xFE at the LOW→HIGH edge.
- Graceful stop, D=8'hFC, `en` dropped in cycle 2 of HIGH:
  - HIGH still lasts 4 cycles and LOW 4 cycles;
  - then state is IDLE with busy=0 and PSI=0;
  - no further `co`.
- Extremes:
  - D=8'hFF: PSI toggles every cycle and `co` stays high continuously.
  - D=8'h00: PSI high 256 cycles and low 256 cycles; `periodDone` is high once per 512 cycles.
- Reset mid-HIGH, D=8'h80, `rst` in cycle 10:
  - PSI=0 and `curDiv`=8'h7F after that edge;
  - with `en` still 1, a new 128/128 period starts on the first edge after `rst` falls.
